// File: rtl/bt_cmd_scheduler.sv
// bt_cmd_scheduler: round-robin TX/RX command sequencer driving bluetooth_encoder and streaming its AT command to the UART.
// Define BT_SCHED_TIMEOUT_EN to abort encoder waits after TIMEOUT_CYCLES cycles.
module bt_cmd_scheduler #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         tx_req,
    input  logic [31:0]  tx_data,
    output logic         tx_ack,
    input  logic         rx_req,
    output logic         rx_ack,
    output logic         enc_start,
    output logic [3:0]   enc_command_select,
    output logic [31:0]  enc_input_data,
    input  logic [143:0] enc_output_data,
    input  logic         enc_done,
    output logic [7:0]   uart_data,
    output logic         uart_valid,
    input  logic         uart_ready,
    output logic         busy,
    output logic         err
);
    typedef enum logic [2:0] {IDLE, START, WAIT_LOW, WAIT_HIGH, SEND} state_t;
    state_t       state;
    logic         last_rx;
    logic [143:0] shift_reg;
    logic [4:0]   cnt;
    logic         pick_tx;
    // TX wins unless RX is also pending and TX was the last one granted
    assign pick_tx = tx_req && (!rx_req || last_rx);
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end
`ifdef BT_SCHED_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tcnt;
    logic          waiting;
    assign waiting = (state == WAIT_LOW && enc_done) || (state == WAIT_HIGH && !enc_done);
`else
    assign err = 1'b0;
`endif
    always_ff @(posedge clk) begin
        if (reset) begin
            state              <= IDLE;
            last_rx            <= 1'b1;
            shift_reg          <= '0;
            cnt                <= '0;
            tx_ack             <= 1'b0;
            rx_ack             <= 1'b0;
            enc_start          <= 1'b0;
            enc_command_select <= 4'h0;
            enc_input_data     <= 32'h0;
            uart_data          <= 8'h0;
            uart_valid         <= 1'b0;
            busy               <= 1'b0;
`ifdef BT_SCHED_TIMEOUT_EN
            tcnt               <= '0;
            err                <= 1'b0;
`endif
        end else begin
            tx_ack    <= 1'b0;
            rx_ack    <= 1'b0;
            enc_start <= 1'b0;
            case (state)
                IDLE: if (tx_req || rx_req) begin
                    state              <= START;
                    busy               <= 1'b1;
                    enc_start          <= 1'b1;
                    tx_ack             <= pick_tx;
                    rx_ack             <= !pick_tx;
                    last_rx            <= !pick_tx;
                    enc_command_select <= pick_tx ? 4'h1 : 4'h2;
                    enc_input_data     <= pick_tx ? tx_data : 32'h0;
                end
                START: state <= WAIT_LOW;
                WAIT_LOW: if (!enc_done) state <= WAIT_HIGH;
                WAIT_HIGH: if (enc_done) begin
                    state      <= SEND;
                    shift_reg  <= enc_output_data;
                    cnt        <= (enc_command_select == 4'h1) ? 5'd18 : 5'd13;
                    uart_valid <= 1'b1;
                    uart_data  <= enc_output_data[7:0];
                end
                SEND: if (uart_ready) begin
                    if (cnt == 5'd1) begin
                        state              <= IDLE;
                        busy               <= 1'b0;
                        uart_valid         <= 1'b0;
                        uart_data          <= 8'h0;
                        enc_command_select <= 4'h0;
                        enc_input_data     <= 32'h0;
                    end else begin
                        shift_reg <= shift_reg >> 8;
                        uart_data <= shift_reg[15:8];
                    end
                    cnt <= cnt - 5'd1;
                end
                default: state <= IDLE;
            endcase
`ifdef BT_SCHED_TIMEOUT_EN
            err <= 1'b0;
            if (state == START || (state == WAIT_LOW && !enc_done)) tcnt <= '0;
            else if (waiting) begin
                tcnt <= tcnt + 1'b1;
                if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
                    err                <= 1'b1;
                    state              <= IDLE;
                    busy               <= 1'b0;
                    enc_command_select <= 4'h0;
                    enc_input_data     <= 32'h0;
                end
            end
`endif
        end
    end
endmodule
